// File: rtl/pll_mdrp_host_if.sv
// ============================================================================
// Module   : pll_mdrp_host_if
// Purpose  : Request/response bus and MDRP-side signals of the PLL MDRP host.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pll_mdrp_host_if;
    // Request side
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] mask;
    logic       busy;
    logic       ack;
    logic       err;
    logic [7:0] rdata;
    // MDRP side (toward the PLL bypass inputs)
    logic       md_inc;
    logic [1:0] md_opc;
    logic [7:0] md_rd_data;
    logic [7:0] md_wr_data;

    // Requester plus PLL side of the link
    modport master (
        output req, we, addr, wdata, mask, md_rd_data,
        input  busy, ack, err, rdata, md_inc, md_opc, md_wr_data
    );

    // The host itself
    modport slave (
        input  req, we, addr, wdata, mask, md_rd_data,
        output busy, ack, err, rdata, md_inc, md_opc, md_wr_data
    );
endinterface

`default_nettype wire

// File: rtl/pll_mdrp_host.sv
// ============================================================================
// Module   : pll_mdrp_host
// Purpose  : Turns random-access read / masked-write requests into the PLL's
//            incrementing-address MDRP sequence (pointer reset, INC, write).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_mdrp_host #(
    parameter int         RD_LAT   = 2,
    parameter logic [7:0] ADDR_MAX = 8'h3F
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pll_mdrp_host_if.slave bus
);

    localparam logic [1:0] c_OPC_RST   = 2'b00;
    localparam logic [1:0] c_OPC_READ  = 2'b10;
    localparam logic [1:0] c_OPC_WRITE = 2'b01;
    localparam logic [2:0] c_LAT_INIT  = 3'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PTR_RST = 3'd1,
        S_SEEK    = 3'd2,
        S_SETTLE  = 3'd3,
        S_WRITE   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t     state_q;
    logic [7:0] ptr_q;
    logic       ptr_vld_q;
    logic       we_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] mask_q;
    logic [2:0] lat_q;
    logic       busy_q;
    logic       ack_q;
    logic       err_q;
    logic [7:0] rdata_q;
    logic       inc_q;
    logic [1:0] opc_q;
    logic [7:0] wr_data_q;

    // Every output is set on the edge that enters the state it belongs to, so
    // a zero-distance seek skips SEEK entirely instead of idling in it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= 8'h00;
            ptr_vld_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            mask_q    <= 8'h00;
            lat_q     <= 3'd0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 8'h00;
            inc_q     <= 1'b0;
            opc_q     <= c_OPC_RST;
            wr_data_q <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    opc_q <= c_OPC_READ;
                    inc_q <= 1'b0;
                    if (bus.req && !busy_q) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        mask_q  <= bus.mask;
                        busy_q  <= 1'b1;
                        if (bus.addr > ADDR_MAX) begin
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else if (!ptr_vld_q || (bus.addr < ptr_q)) begin
                            // The PLL pointer only counts up, or is unknown after reset
                            opc_q   <= c_OPC_RST;
                            state_q <= S_PTR_RST;
                        end else if (bus.addr == ptr_q) begin
                            lat_q   <= c_LAT_INIT;
                            state_q <= S_SETTLE;
                        end else begin
                            inc_q   <= 1'b1;
                            state_q <= S_SEEK;
                        end
                    end
                end

                S_PTR_RST: begin
                    ptr_q     <= 8'h00;
                    ptr_vld_q <= 1'b1;
                    opc_q     <= c_OPC_READ;
                    if (addr_q == 8'h00) begin
                        lat_q   <= c_LAT_INIT;
                        state_q <= S_SETTLE;
                    end else begin
                        inc_q   <= 1'b1;
                        state_q <= S_SEEK;
                    end
                end

                S_SEEK: begin
                    ptr_q <= ptr_q + 8'd1;
                    if ((ptr_q + 8'd1) == addr_q) begin
                        inc_q   <= 1'b0;
                        lat_q   <= c_LAT_INIT;
                        state_q <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (lat_q != 3'd0) begin
                        lat_q <= lat_q - 3'd1;
                    end else begin
                        rdata_q <= bus.md_rd_data;
                        if (we_q) begin
                            wr_data_q <= (bus.md_rd_data & ~mask_q) | (wdata_q & mask_q);
                            opc_q     <= c_OPC_WRITE;
                            state_q   <= S_WRITE;
                        end else begin
                            ack_q   <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end

                S_WRITE: begin
                    opc_q   <= c_OPC_READ;
                    ack_q   <= 1'b1;
                    state_q <= S_DONE;
                end

                S_DONE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.ack        = ack_q;
    assign bus.err        = err_q;
    assign bus.rdata      = rdata_q;
    assign bus.md_inc     = inc_q;
    assign bus.md_opc     = opc_q;
    assign bus.md_wr_data = wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_mdrp_host.sv
// ============================================================================
// Module   : tb_pll_mdrp_host
// Purpose  : Self-checking bench for pll_mdrp_host against a PLL register model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pll_mdrp_host;

    localparam int RD_LAT = 2;

    logic clk;
    logic rst;
    pll_mdrp_host_if bus ();

    pll_mdrp_host #(.RD_LAT(RD_LAT), .ADDR_MAX(8'h3F)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- PLL register file model ----------------
    logic [7:0] regs [256];
    logic [7:0] pll_ptr;
    int         settle;
    logic       bd_we;
    logic [7:0] bd_addr;
    logic [7:0] bd_val;

    always @(posedge clk) begin
        if (bd_we)
            regs[bd_addr] <= bd_val;
        else if (bus.md_opc == 2'b01)
            regs[pll_ptr] <= bus.md_wr_data;
        if (bus.md_opc == 2'b00) begin
            pll_ptr <= 8'h00;
            settle  <= 0;
        end else if (bus.md_inc) begin
            pll_ptr <= pll_ptr + 8'd1;
            settle  <= 0;
        end else if (settle < 1000) begin
            settle <= settle + 1;
        end
    end

    // Data is only valid RD_LAT cycles after the pointer last moved
    assign bus.md_rd_data = (settle >= RD_LAT - 1) ? regs[pll_ptr] : ~regs[pll_ptr];

    // ---------------- reference model of the host ----------------
    typedef struct {
        int         lat;
        int         n_rst;
        int         n_inc;
        int         n_wr;
        logic [7:0] wval;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    typedef struct {
        int         lat;
        int         n_rst;
        int         n_inc;
        int         n_wr;
        logic [7:0] wval;
        logic [7:0] rdata;
        logic       err;
        bit         ok;
        logic       busy1;
        logic       ack2;
        logic       busy2;
    } obs_t;

    logic [7:0] shadow [64];
    logic [7:0] ref_ptr;
    bit         ref_vld;
    logic [7:0] ref_rdata;
    logic [7:0] ref_wval;

    int n_vec = 0;
    int n_mis = 0;

    task automatic model_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                             input logic [7:0] mask, output exp_t e);
        bit   need_rst;
        int   start;
        e.err = (addr > 8'h3F);
        e.n_wr = 0;
        if (e.err) begin
            e.lat = 0; e.n_rst = 0; e.n_inc = 0;
        end else begin
            need_rst = !ref_vld || (addr < ref_ptr);
            start    = need_rst ? 0 : int'(ref_ptr);
            e.n_rst  = need_rst ? 1 : 0;
            e.n_inc  = int'(addr) - start;
            e.lat    = e.n_rst + e.n_inc + RD_LAT + (we ? 1 : 0);
            ref_rdata = shadow[addr[5:0]];
            if (we) begin
                ref_wval = (ref_rdata & ~mask) | (wdata & mask);
                shadow[addr[5:0]] = ref_wval;
                e.n_wr = 1;
            end
            ref_ptr = addr;
            ref_vld = 1'b1;
        end
        e.rdata = ref_rdata;
        e.wval  = ref_wval;
    endtask

    task automatic poke(input logic [7:0] addr, input logic [7:0] val);
        bd_we = 1'b1; bd_addr = addr; bd_val = val;
        shadow[addr[5:0]] = val;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Drives one request and records what the DUT did; checking is left to callers
    task automatic txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [7:0] mask, output obs_t o);
        o.lat = 0; o.n_rst = 0; o.n_inc = 0; o.n_wr = 0; o.wval = 8'h00;
        o.rdata = 8'h00; o.err = 1'b0; o.ok = 1'b0; o.busy1 = 1'b0;
        o.ack2 = 1'b0; o.busy2 = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 100 && bus.busy; k++) @(negedge clk);
        bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata; bus.mask = mask;
        @(posedge clk); #1;
        bus.req = 1'b0; bus.we = 1'($urandom); bus.addr = 8'($urandom);
        bus.wdata = 8'($urandom); bus.mask = 8'($urandom);
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (k == 0) o.busy1 = bus.busy;
            if (bus.ack) begin
                o.ok = 1'b1; o.rdata = bus.rdata; o.err = bus.err;
                break;
            end
            if (bus.md_opc == 2'b00) o.n_rst++;
            if (bus.md_inc) o.n_inc++;
            if (bus.md_opc == 2'b01) begin o.n_wr++; o.wval = bus.md_wr_data; end
            o.lat++;
        end
        @(negedge clk);
        o.ack2 = bus.ack; o.busy2 = bus.busy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; bd_we = 1'b0; bd_addr = 8'h00; bd_val = 8'h00;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 8'h00; bus.wdata = 8'h00; bus.mask = 8'h00;
        for (int i = 0; i < 64; i++) poke(8'(i), 8'($urandom));
        ref_ptr = 8'h00; ref_vld = 1'b0; ref_rdata = 8'h00; ref_wval = 8'h00;
        @(negedge clk);
        n_vec++;
        if ({bus.busy, bus.ack, bus.err, bus.rdata, bus.md_inc, bus.md_opc, bus.md_wr_data} !== 28'h0) begin
            n_mis++;
            $display("FAIL reset_outputs: got busy=%b ack=%b err=%b rdata=%h inc=%b opc=%b wr=%h want all zero",
                     bus.busy, bus.ack, bus.err, bus.rdata, bus.md_inc, bus.md_opc, bus.md_wr_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_after_reset();
        obs_t o; exp_t e;
        poke(8'h0B, 8'h41);
        model_txn(1'b0, 8'h0B, 8'h00, 8'h00, e);
        txn(1'b0, 8'h0B, 8'h00, 8'h00, o);
        n_vec++; if (o.n_rst !== 1) begin n_mis++; $display("FAIL rd0b_ptr_rst: got %0d want 1", o.n_rst); end
        n_vec++; if (o.n_inc !== 11) begin n_mis++; $display("FAIL rd0b_inc: got %0d want 11", o.n_inc); end
        n_vec++; if (o.rdata !== 8'h41 || o.err !== 1'b0) begin n_mis++; $display("FAIL rd0b_data: got %h err=%b want 41 err=0", o.rdata, o.err); end
        n_vec++; if (o.lat + 1 !== 15) begin n_mis++; $display("FAIL rd0b_cycles: got %0d want 15", o.lat + 1); end
        n_vec++; if (o.busy1 !== 1'b1 || o.ack2 !== 1'b0 || o.busy2 !== 1'b0) begin n_mis++; $display("FAIL rd0b_handshake: got busy1=%b ack2=%b busy2=%b want 1 0 0", o.busy1, o.ack2, o.busy2); end
    endtask

    task automatic test_write_merge();
        obs_t o; exp_t e;
        poke(8'h11, 8'hF8);
        model_txn(1'b1, 8'h11, 8'h03, 8'h07, e);
        txn(1'b1, 8'h11, 8'h03, 8'h07, o);
        n_vec++; if (o.rdata !== 8'hF8) begin n_mis++; $display("FAIL wr11_rdata: got %h want f8", o.rdata); end
        n_vec++; if (o.n_wr !== 1 || o.wval !== 8'hFB) begin n_mis++; $display("FAIL wr11_opc01: got n=%0d data=%h want n=1 data=fb", o.n_wr, o.wval); end
        n_vec++; if (regs[8'h11] !== 8'hFB) begin n_mis++; $display("FAIL wr11_reg: got %h want fb", regs[8'h11]); end
        n_vec++; if (o.lat !== e.lat) begin n_mis++; $display("FAIL wr11_lat: got %0d want %0d", o.lat, e.lat); end
    endtask

    task automatic test_ptr_reuse();
        obs_t o; exp_t e;
        model_txn(1'b0, 8'h12, 8'h00, 8'h00, e);
        txn(1'b0, 8'h12, 8'h00, 8'h00, o);
        model_txn(1'b0, 8'h0C, 8'h00, 8'h00, e);
        txn(1'b0, 8'h0C, 8'h00, 8'h00, o);
        n_vec++; if (o.n_rst !== 1 || o.n_inc !== 12) begin n_mis++; $display("FAIL back_seek: got rst=%0d inc=%0d want 1 12", o.n_rst, o.n_inc); end
        n_vec++; if (o.rdata !== e.rdata) begin n_mis++; $display("FAIL back_data: got %h want %h", o.rdata, e.rdata); end
        model_txn(1'b0, 8'h0C, 8'h00, 8'h00, e);
        txn(1'b0, 8'h0C, 8'h00, 8'h00, o);
        n_vec++; if (o.n_rst !== 0 || o.n_inc !== 0) begin n_mis++; $display("FAIL same_addr: got rst=%0d inc=%0d want 0 0", o.n_rst, o.n_inc); end
        n_vec++; if (o.lat !== RD_LAT) begin n_mis++; $display("FAIL same_lat: got %0d want %0d", o.lat, RD_LAT); end
    endtask

    task automatic test_error();
        obs_t o; exp_t e;
        logic [7:0] prev;
        prev = ref_rdata;
        model_txn(1'b1, 8'h40, 8'hAA, 8'hFF, e);
        txn(1'b1, 8'h40, 8'hAA, 8'hFF, o);
        n_vec++; if (o.err !== 1'b1 || o.lat !== 0) begin n_mis++; $display("FAIL err40_ack: got err=%b lat=%0d want 1 0", o.err, o.lat); end
        n_vec++; if (o.n_rst + o.n_inc + o.n_wr !== 0) begin n_mis++; $display("FAIL err40_mdrp: got rst=%0d inc=%0d wr=%0d want none", o.n_rst, o.n_inc, o.n_wr); end
        n_vec++; if (o.rdata !== prev) begin n_mis++; $display("FAIL err40_rdata: got %h want %h", o.rdata, prev); end
        n_vec++; if (pll_ptr !== ref_ptr) begin n_mis++; $display("FAIL err40_ptr: got %h want %h", pll_ptr, ref_ptr); end
    endtask

    task automatic test_ignore_req();
        obs_t o; exp_t e;
        int acks; bit got;
        model_txn(1'b0, 8'h01, 8'h00, 8'h00, e);
        txn(1'b0, 8'h01, 8'h00, 8'h00, o);
        model_txn(1'b0, 8'h20, 8'h00, 8'h00, e);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 8'h20;
        @(posedge clk); #1 bus.req = 1'b0;
        repeat (3) @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 8'h05; bus.wdata = ~shadow[5]; bus.mask = 8'hFF;
        @(negedge clk);
        bus.req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus.ack) begin got = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++; if (!got || bus.rdata !== e.rdata) begin n_mis++; $display("FAIL ign_data: got ack=%b data=%h want 1 %h", got, bus.rdata, e.rdata); end
        acks = 0;
        repeat (30) begin @(negedge clk); if (bus.ack) acks++; end
        n_vec++; if (acks !== 0) begin n_mis++; $display("FAIL ign_extra_ack: got %0d want 0", acks); end
        n_vec++; if (regs[8'h05] !== shadow[5]) begin n_mis++; $display("FAIL ign_no_write: got %h want %h", regs[8'h05], shadow[5]); end
    endtask

    task automatic test_reset_mid_seek();
        obs_t o; exp_t e;
        int acks;
        model_txn(1'b0, 8'h02, 8'h00, 8'h00, e);
        txn(1'b0, 8'h02, 8'h00, 8'h00, o);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 8'h3A;
        @(posedge clk); #1 bus.req = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++; if (bus.md_inc !== 1'b1) begin n_mis++; $display("FAIL mid_in_seek: got inc=%b want 1", bus.md_inc); end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.busy, bus.ack, bus.err, bus.rdata, bus.md_inc, bus.md_opc, bus.md_wr_data} !== 28'h0) begin
            n_mis++;
            $display("FAIL mid_reset_outputs: got busy=%b ack=%b err=%b rdata=%h inc=%b opc=%b wr=%h want all zero",
                     bus.busy, bus.ack, bus.err, bus.rdata, bus.md_inc, bus.md_opc, bus.md_wr_data);
        end
        ref_ptr = 8'h00; ref_vld = 1'b0; ref_rdata = 8'h00; ref_wval = 8'h00;
        @(negedge clk) rst = 1'b0;
        acks = 0;
        repeat (30) begin @(negedge clk); if (bus.ack) acks++; end
        n_vec++; if (acks !== 0) begin n_mis++; $display("FAIL mid_no_ack: got %0d want 0", acks); end
        model_txn(1'b0, 8'h3A, 8'h00, 8'h00, e);
        txn(1'b0, 8'h3A, 8'h00, 8'h00, o);
        n_vec++; if (o.n_rst !== 1 || o.n_inc !== 58) begin n_mis++; $display("FAIL mid_reissue: got rst=%0d inc=%0d want 1 58", o.n_rst, o.n_inc); end
        n_vec++; if (o.rdata !== e.rdata) begin n_mis++; $display("FAIL mid_data: got %h want %h", o.rdata, e.rdata); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [6];
        exp_t e;
        int acks; bit got;
        seq[0] = 8'h07; seq[1] = 8'h07; seq[2] = 8'h2C; seq[3] = 8'h03; seq[4] = 8'h3F; seq[5] = 8'h41;
        acks = 0;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = seq[0];
        for (int i = 0; i < 6; i++) begin
            model_txn(1'b0, seq[i], 8'h00, 8'h00, e);
            got = 1'b0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (bus.ack) begin got = 1'b1; break; end
            end
            if (got) acks++;
            n_vec++;
            if (!got || bus.rdata !== e.rdata || bus.err !== e.err) begin
                n_mis++;
                $display("FAIL b2b[%0d]: got ack=%b data=%h err=%b want 1 %h %b", i, got, bus.rdata, bus.err, e.rdata, e.err);
            end
            if (i < 5) bus.addr = seq[i+1];
            else bus.req = 1'b0;
        end
        repeat (20) begin @(negedge clk); if (bus.ack) acks++; end
        n_vec++; if (acks !== 6) begin n_mis++; $display("FAIL b2b_ack_count: got %0d want 6", acks); end
    endtask

    task automatic test_random();
        obs_t o; exp_t e;
        logic       we;
        logic [7:0] addr, wdata, mask;
        for (int i = 0; i < 40; i++) begin
            we    = 1'($urandom);
            addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
            wdata = 8'($urandom);
            mask  = (i == 5) ? 8'h00 : 8'($urandom);
            model_txn(we, addr, wdata, mask, e);
            txn(we, addr, wdata, mask, o);
            n_vec++;
            if (!o.ok || o.err !== e.err || o.rdata !== e.rdata) begin
                n_mis++;
                $display("FAIL rand[%0d] result a=%h we=%b: got ok=%b err=%b data=%h want err=%b data=%h",
                         i, addr, we, o.ok, o.err, o.rdata, e.err, e.rdata);
            end
            n_vec++;
            if (o.lat !== e.lat || o.n_rst !== e.n_rst || o.n_inc !== e.n_inc || o.n_wr !== e.n_wr) begin
                n_mis++;
                $display("FAIL rand[%0d] sequence a=%h: got lat=%0d rst=%0d inc=%0d wr=%0d want %0d %0d %0d %0d",
                         i, addr, o.lat, o.n_rst, o.n_inc, o.n_wr, e.lat, e.n_rst, e.n_inc, e.n_wr);
            end
            if (e.n_wr == 1) begin
                n_vec++;
                if (o.wval !== e.wval || regs[addr] !== e.wval) begin
                    n_mis++;
                    $display("FAIL rand[%0d] write a=%h: got wr=%h reg=%h want %h", i, addr, o.wval, regs[addr], e.wval);
                end
            end
            n_vec++;
            if (pll_ptr !== ref_ptr || o.ack2 !== 1'b0 || o.busy2 !== 1'b0) begin
                n_mis++;
                $display("FAIL rand[%0d] tail: got ptr=%h ack2=%b busy2=%b want %h 0 0", i, pll_ptr, o.ack2, o.busy2, ref_ptr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write_merge();
        test_ptr_reuse();
        test_error();
        test_ignore_req();
        test_reset_mid_seek();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
